dip_led_scheduler: RTL and testbench
====================================

Name: dip_led_scheduler

Overview:
- Samples the eight active-low DIP switches on PMOD A and debounces them.
- Treats each asserted switch as a requester for the board's two active-low LEDs.
- Grants the LEDs round-robin, one requester per slot. During its slot, the owner's index is shown as a count of green blinks (index+1), with red steady-on.
- Replaces raw gate wiring from switches to LEDs as the single owner of LEDG_N/LEDR_N in the top level.

Parameters:
- CLK_HZ, 12000000, input clock frequency.
- TICK_HZ, 1000, scheduler/debounce tick rate; tick period = CLK_HZ/TICK_HZ cycles (integer, >=2).
- DB_TICKS, 10, ticks a switch must differ from its debounced value before the change is accepted.
- ON_TICKS, 150, ticks the green LED is lit per blink.
- OFF_TICKS, 150, ticks the green LED is dark between blinks.
- GAP_TICKS, 600, ticks both LEDs are dark between slots.

Ports:
- CLK  in  1  12 MHz clock.
- RST_N  in  1  asynchronous active-low reset.
- SW_N  in  8  raw switch pins {P1A10,P1A9,P1A8,P1A7,P1A4,P1A3,P1A2,P1A1}; low = switch on.
- SW_DB  out  8  debounced switches, active-high.
- GRANT  out  8  one-hot current owner; all-zero when no owner.
- GRANT_VLD  out  1  high while in ON or OFF.
- LEDG_N  out  1  green LED, active-low.
- LEDR_N  out  1  red LED, active-low.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous, active-low. All flops reset asynchronously.
- Reset values:
  - SW_DB=0, GRANT=0, GRANT_VLD=0, LEDG_N=1, LEDR_N=1.
  - Synchronizer flops = 8'hFF.
  - rr_ptr=0, state=IDLE, all counters 0.
- Tick: free-running divider counts 0..CLK_HZ/TICK_HZ-1. tick is a one-cycle pulse at the terminal count.
- Input sync: 2-flop synchronizer per bit; sw_s = ~sync2.
- Debounce, per bit:
  - If sw_s != SW_DB, the counter increments on each tick.
  - When the counter reaches DB_TICKS, SW_DB flips and the counter clears.
  - If sw_s == SW_DB, the counter clears on any cycle.
  - A bounce shorter than DB_TICKS ticks is never seen.
- Scheduler FSM; the per-state tick counter tcnt clears on every state entry:
  - IDLE:
    - LEDs off.
    - If |SW_DB, go to PICK next cycle.
  - PICK (exactly 1 cycle):
    - Scan from rr_ptr upward, mod 8; first set SW_DB bit wins → GRANT=onehot(idx), blink_cnt=idx+1, go ON.
    - If no bit is set, go IDLE.
  - ON:
    - LEDG_N=0, LEDR_N=0.
    - After ON_TICKS ticks: blink_cnt--, go OFF.
  - OFF:
    - LEDG_N=1, LEDR_N=0.
    - After OFF_TICKS ticks: if blink_cnt!=0 go ON, else go GAP.
  - GAP:
    - LEDs off, GRANT=0.
    - After GAP_TICKS ticks go PICK.
- rr_ptr update: on exit from ON/OFF toward GAP, rr_ptr = granted idx+1 (wraps 7→0).
- Abort: if the granted bit of SW_DB falls during ON or OFF, go to GAP on the next cycle. rr_ptr still advances past the aborted owner.
- Non-owner changes during a slot only affect the next PICK.
- Single requester: re-granted every slot after GAP; no starvation. With k requesters, each is served once per k slots.
- LED outputs are registered: one cycle after the state register.
- Asserting RST_N mid-slot darkens the LEDs immediately and restarts from IDLE with rr_ptr=0.

Decomposition:
- Package funpga_pkg:
  - FSM state encodings: IDLE, PICK, ON, OFF, GAP.
  - LED_ON=1'b0 and LED_OFF=1'b1.
  - Clog2 helper for counter widths.
- Sub-module sw_debounce holds the synchronizer plus per-bit debounce counters, parameterised by width and DB_TICKS, fed by the tick.
- The tick divider stays in the top level and is shared by the debouncer and the FSM.

Test Plan:
Bench uses CLK_HZ=1000, TICK_HZ=100 (tick every 10 cycles), DB_TICKS=2, ON_TICKS=1, OFF_TICKS=1, GAP_TICKS=3.
- Reset: hold RST_N low for 5 cycles → LEDG_N=1, LEDR_N=1, GRANT=0, SW_DB=0. Release with SW_N=FF → stays IDLE, LEDs dark indefinitely.
- Debounce: SW_N[0] low for 1 tick then high → SW_DB stays 0. Hold low for 3 ticks → SW_DB[0]=1 within 2 ticks + 3 cycles.
- Single requester: switch 2 on → GRANT=8'h04 and three green pulses of 1 tick each, red low throughout; then 3-tick dark gap, then repeat.
- Round robin: switches 1, 5 and 6 on, rr_ptr=0 → grant order 1,5,6,1,… with green pulse counts 2,6,7.
- Abort: release switch 5 mid-ON → after debounce, next cycle GAP, GRANT=0. The next PICK selects 6, not 5.
- Async reset: assert RST_N during OFF → outputs return to reset values in the same cycle, without waiting for a clock edge. After release, the first grant is the lowest active index.

Source files
------------

// File: rtl/funpga_pkg.sv
// rtl/funpga_pkg.sv - shared state encodings, LED polarity and width helper
package funpga_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PICK = 3'd1,
    S_ON   = 3'd2,
    S_OFF  = 3'd3,
    S_GAP  = 3'd4
  } sched_state_e;

  // Board LEDs are active-low.
  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;

  // Bits needed to hold values 0..max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchronizer plus per-bit tick-based debounce
module sw_debounce
  import funpga_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DB_TICKS = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] sw_n_i,
  output logic [WIDTH-1:0] sw_db_o
);

  localparam int CW = cnt_width(DB_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] sw_s;
  logic [WIDTH-1:0] db_q, db_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // Switches are active-low on the pins; present them active-high.
  assign sw_s    = ~sync2_q;
  assign sw_db_o = db_q;

  // Resync raw pins; idle state (all released) is all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sw_n_i;
      sync2_q <= sync1_q;
    end
  end

  // A bit flips only after disagreeing for DB_TICKS consecutive ticks.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sw_s[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_i) begin
        if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i] = '0;
          db_d[i]  = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounced value and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/dip_led_scheduler.sv
// rtl/dip_led_scheduler.sv - round-robin LED owner scheduler driven by DIP switches
module dip_led_scheduler
  import funpga_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int TICK_HZ   = 1000,
  parameter int DB_TICKS  = 10,
  parameter int ON_TICKS  = 150,
  parameter int OFF_TICKS = 150,
  parameter int GAP_TICKS = 600
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] SW_N,
  output logic [7:0] SW_DB,
  output logic [7:0] GRANT,
  output logic       GRANT_VLD,
  output logic       LEDG_N,
  output logic       LEDR_N
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int DW   = cnt_width(DIV - 1);
  localparam int MAXT = (ON_TICKS > OFF_TICKS)
                        ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                        : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int TW   = cnt_width(MAXT);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

  logic [DW-1:0] div_q;
  logic          tick;
  logic [7:0]    sw_db;

  sched_state_e  state_q;
  logic [TW-1:0] tcnt_q;
  logic [2:0]    rr_ptr_q;
  logic [2:0]    own_q;
  logic [3:0]    blink_q;
  logic [7:0]    grant_q;
  logic          vld_q;
  logic          ledg_q;
  logic          ledr_q;

  logic          pick_found;
  logic [2:0]    pick_idx;
  logic [2:0]    cand;
  logic          owner_lost;

  assign tick = (div_q == DIV_LAST);

  // Free-running tick divider shared by debounce and scheduler.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) div_q <= '0;
    else if (tick) div_q <= '0;
    else div_q <= div_q + DW'(1);
  end

  sw_debounce #(
    .WIDTH    (8),
    .DB_TICKS (DB_TICKS)
  ) u_sw_debounce (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .tick_i  (tick),
    .sw_n_i  (SW_N),
    .sw_db_o (sw_db)
  );

  // First requester at or after rr_ptr, wrapping; lowest offset wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = rr_ptr_q;
    for (int i = 7; i >= 0; i--) begin
      cand = rr_ptr_q + 3'(i);
      if (sw_db[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_lost = !sw_db[own_q];

  // Scheduler FSM; outputs are registered from the current state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      tcnt_q   <= '0;
      rr_ptr_q <= '0;
      own_q    <= '0;
      blink_q  <= '0;
      grant_q  <= '0;
      vld_q    <= 1'b0;
      ledg_q   <= LED_OFF;
      ledr_q   <= LED_OFF;
    end else begin
      ledg_q  <= (state_q == S_ON) ? LED_ON : LED_OFF;
      ledr_q  <= (state_q == S_ON || state_q == S_OFF) ? LED_ON : LED_OFF;
      vld_q   <= (state_q == S_ON || state_q == S_OFF);
      grant_q <= (state_q == S_ON || state_q == S_OFF) ? (8'd1 << own_q) : 8'd0;

      case (state_q)
        S_IDLE: begin
          if (|sw_db) begin
            state_q <= S_PICK;
            tcnt_q  <= '0;
          end
        end
        S_PICK: begin
          tcnt_q <= '0;
          if (pick_found) begin
            own_q   <= pick_idx;
            blink_q <= {1'b0, pick_idx} + 4'd1;
            state_q <= S_ON;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ON: begin
          if (owner_lost) begin
            state_q  <= S_GAP;
            tcnt_q   <= '0;
            rr_ptr_q <= own_q + 3'd1;
          end else if (tick) begin
            if (tcnt_q == ON_LAST) begin
              blink_q <= blink_q - 4'd1;
              state_q <= S_OFF;
              tcnt_q  <= '0;
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        S_OFF: begin
          if (owner_lost) begin
            state_q  <= S_GAP;
            tcnt_q   <= '0;
            rr_ptr_q <= own_q + 3'd1;
          end else if (tick) begin
            if (tcnt_q == OFF_LAST) begin
              tcnt_q <= '0;
              if (blink_q != 4'd0) begin
                state_q <= S_ON;
              end else begin
                state_q  <= S_GAP;
                rr_ptr_q <= own_q + 3'd1;
              end
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (tcnt_q == GAP_LAST) begin
              state_q <= S_PICK;
              tcnt_q  <= '0;
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tcnt_q  <= '0;
        end
      endcase
    end
  end

  assign SW_DB     = sw_db;
  assign GRANT     = grant_q;
  assign GRANT_VLD = vld_q;
  assign LEDG_N    = ledg_q;
  assign LEDR_N    = ledr_q;

endmodule

// File: tb/tb_dip_led_scheduler.sv
// tb/tb_dip_led_scheduler.sv - randomized self-checking bench for dip_led_scheduler
module tb_dip_led_scheduler;

  logic       CLK;
  logic       RST_N;
  logic [7:0] SW_N;
  logic [7:0] SW_DB;
  logic [7:0] GRANT;
  logic       GRANT_VLD;
  logic       LEDG_N;
  logic       LEDR_N;

  int checks = 0;
  int errors = 0;

  dip_led_scheduler #(
    .CLK_HZ    (1000),
    .TICK_HZ   (100),
    .DB_TICKS  (2),
    .ON_TICKS  (1),
    .OFF_TICKS (1),
    .GAP_TICKS (3)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SW_N      (SW_N),
    .SW_DB     (SW_DB),
    .GRANT     (GRANT),
    .GRANT_VLD (GRANT_VLD),
    .LEDG_N    (LEDG_N),
    .LEDR_N    (LEDR_N)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] grant;
    int         pulses;
    int         gap;
    bit         red_bad;
    bit         grant_changed;
    int         min_on;
    int         max_on;
  } slot_t;

  slot_t slot_q[$];
  slot_t cur;
  bit    in_slot = 0;
  int    dark = 0;
  int    on_w = 0;

  // Observes outputs away from the active edge and records each owner slot.
  always @(negedge CLK) begin
    if (!RST_N) begin
      in_slot = 0;
      dark    = 0;
      on_w    = 0;
    end else if (!in_slot) begin
      if (GRANT != 8'd0) begin
        cur.grant = GRANT; cur.pulses = 0; cur.gap = dark;
        cur.red_bad = 0; cur.grant_changed = 0; cur.min_on = 1000; cur.max_on = 0;
        in_slot = 1; on_w = 0;
      end else begin
        dark = dark + 1;
      end
    end
    if (RST_N && in_slot) begin
      if (GRANT == 8'd0) begin
        if (on_w > 0) begin
          if (on_w < cur.min_on) cur.min_on = on_w;
          if (on_w > cur.max_on) cur.max_on = on_w;
        end
        slot_q.push_back(cur);
        in_slot = 0; dark = 1; on_w = 0;
      end else begin
        if (GRANT != cur.grant) cur.grant_changed = 1;
        if (LEDR_N !== 1'b0) cur.red_bad = 1;
        if (LEDG_N === 1'b0) begin
          if (on_w == 0) cur.pulses = cur.pulses + 1;
          on_w = on_w + 1;
        end else begin
          if (on_w > 0) begin
            if (on_w < cur.min_on) cur.min_on = on_w;
            if (on_w > cur.max_on) cur.max_on = on_w;
          end
          on_w = 0;
        end
      end
    end
  end

  // Reference round-robin: first set switch at or after ptr, modulo 8.
  function automatic int next_owner(input logic [7:0] mask, input int ptr);
    for (int k = 0; k < 8; k++) if (mask[(ptr + k) % 8]) return (ptr + k) % 8;
    return -1;
  endfunction

  function automatic int popcount8(input logic [7:0] v);
    int n = 0;
    for (int k = 0; k < 8; k++) n += int'(v[k]);
    return n;
  endfunction

  task automatic do_reset(input logic [7:0] mask);
    RST_N = 1'b0;
    SW_N  = ~mask;
    repeat (5) @(negedge CLK);
    slot_q.delete();
    RST_N = 1'b1;
  endtask

  task automatic wait_slot(output slot_t s, output bit ok);
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge CLK);
      if (slot_q.size() > 0) begin
        s  = slot_q.pop_front();
        ok = 1;
      end
    end
  endtask

  task automatic test_reset;
    bit lit;
    RST_N = 1'b0;
    SW_N  = 8'hFF;
    repeat (5) @(negedge CLK);
    checks++; if (LEDG_N !== 1'b1) begin errors++; $display("FAIL reset_ledg got=%b exp=1", LEDG_N); end
    checks++; if (LEDR_N !== 1'b1) begin errors++; $display("FAIL reset_ledr got=%b exp=1", LEDR_N); end
    checks++; if (GRANT !== 8'h00) begin errors++; $display("FAIL reset_grant got=%h exp=00", GRANT); end
    checks++; if (SW_DB !== 8'h00) begin errors++; $display("FAIL reset_swdb got=%h exp=00", SW_DB); end
    checks++; if (GRANT_VLD !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", GRANT_VLD); end
    RST_N = 1'b1;
    lit = 0;
    repeat (100) begin
      @(negedge CLK);
      if (LEDG_N !== 1'b1 || LEDR_N !== 1'b1 || GRANT !== 8'h00) lit = 1;
    end
    checks++; if (lit) begin errors++; $display("FAIL idle_dark got=lit exp=dark"); end
  endtask

  task automatic test_debounce;
    bit seen;
    int lat;
    SW_N[0] = 1'b0;
    repeat (10) @(negedge CLK);
    SW_N[0] = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (SW_DB !== 8'h00) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL short_bounce got=seen exp=ignored"); end
    SW_N[0] = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      @(negedge CLK);
      if (SW_DB[0] === 1'b1) lat = i;
    end
    checks++; if (lat < 0 || lat > 23) begin errors++; $display("FAIL debounce_latency got=%0d exp<=23", lat); end
    checks++; if (SW_DB !== 8'h01) begin errors++; $display("FAIL debounce_value got=%h exp=01", SW_DB); end
    repeat (10) @(negedge CLK);
    SW_N = 8'hFF;
    repeat (40) @(negedge CLK);
    checks++; if (SW_DB !== 8'h00) begin errors++; $display("FAIL debounce_release got=%h exp=00", SW_DB); end
  endtask

  task automatic test_single;
    slot_t s;
    bit ok;
    do_reset(8'h04);
    for (int n = 0; n < 2; n++) begin
      wait_slot(s, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout slot=%0d got=none exp=slot", n); end
      else begin
        checks++; if (s.grant !== 8'h04 || s.grant_changed) begin errors++; $display("FAIL single_grant got=%h exp=04", s.grant); end
        checks++; if (s.pulses != 3) begin errors++; $display("FAIL single_pulses got=%0d exp=3", s.pulses); end
        checks++; if (s.red_bad) begin errors++; $display("FAIL single_red got=off exp=on"); end
        checks++; if (s.min_on < 1 || s.max_on > 10) begin errors++; $display("FAIL single_width got=%0d..%0d exp=1..10", s.min_on, s.max_on); end
        if (n == 1) begin
          checks++; if (s.gap < 20 || s.gap > 32) begin errors++; $display("FAIL single_gap got=%0d exp=20..32", s.gap); end
        end
      end
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] masks [4];
    slot_t s;
    bit ok;
    int ptr, idx, nslots;
    logic [7:0] eg;
    masks[0] = 8'h62;
    for (int m = 1; m < 4; m++) masks[m] = 8'($urandom_range(1, 255));
    for (int m = 0; m < 4; m++) begin
      do_reset(masks[m]);
      ptr = 0;
      nslots = popcount8(masks[m]) + 1;
      for (int n = 0; n < nslots; n++) begin
        idx = next_owner(masks[m], ptr);
        eg  = 8'd1 << idx;
        ptr = (idx + 1) % 8;
        wait_slot(s, ok);
        checks++;
        if (!ok) begin
          errors++; $display("FAIL rr_timeout mask=%h slot=%0d got=none exp=%h", masks[m], n, eg);
          break;
        end
        if (s.grant !== eg || s.pulses != idx + 1 || s.grant_changed || s.red_bad) begin
          errors++;
          $display("FAIL rr_slot mask=%h slot=%0d got=%h/%0d exp=%h/%0d", masks[m], n, s.grant, s.pulses, eg, idx + 1);
        end
      end
    end
  endtask

  task automatic test_abort;
    slot_t s;
    bit ok, hit;
    do_reset(8'h62);
    wait_slot(s, ok);
    checks++; if (!ok || s.grant !== 8'h02) begin errors++; $display("FAIL abort_first got=%h exp=02", s.grant); end
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge CLK);
      if (GRANT === 8'h20 && LEDG_N === 1'b0) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_wait_on got=none exp=on5"); end
    SW_N[5] = 1'b1;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge CLK);
      if (SW_DB[5] === 1'b0) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_debounce got=%h exp=bit5 low", SW_DB); end
    repeat (2) @(negedge CLK);
    checks++; if (GRANT !== 8'h00 || GRANT_VLD !== 1'b0) begin errors++; $display("FAIL abort_gap got=%h exp=00", GRANT); end
    wait_slot(s, ok);
    checks++; if (!ok || s.grant !== 8'h20 || s.pulses >= 6) begin errors++; $display("FAIL abort_cut got=%h/%0d exp=20/<6", s.grant, s.pulses); end
    wait_slot(s, ok);
    checks++; if (!ok || s.grant !== 8'h40 || s.pulses != 7) begin errors++; $display("FAIL abort_next got=%h/%0d exp=40/7", s.grant, s.pulses); end
  endtask

  task automatic test_async_reset;
    slot_t s;
    bit ok, hit;
    logic [7:0] mask;
    logic [7:0] eg;
    mask = 8'($urandom_range(1, 255));
    if (popcount8(mask) < 2) mask = mask | 8'h81;
    do_reset(mask);
    wait_slot(s, ok);
    checks++; if (!ok) begin errors++; $display("FAIL async_first got=none exp=slot"); end
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge CLK);
      if (GRANT_VLD === 1'b1 && LEDG_N === 1'b1 && LEDR_N === 1'b0) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL async_wait_off got=none exp=off"); end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (LEDG_N !== 1'b1 || LEDR_N !== 1'b1 || GRANT !== 8'h00 || GRANT_VLD !== 1'b0 || SW_DB !== 8'h00) begin
      errors++;
      $display("FAIL async_outputs got=%b%b/%h/%b/%h exp=11/00/0/00", LEDG_N, LEDR_N, GRANT, GRANT_VLD, SW_DB);
    end
    repeat (3) @(negedge CLK);
    slot_q.delete();
    RST_N = 1'b1;
    eg = 8'd1 << next_owner(mask, 0);
    wait_slot(s, ok);
    checks++; if (!ok || s.grant !== eg) begin errors++; $display("FAIL async_regrant mask=%h got=%h exp=%h", mask, s.grant, eg); end
  endtask

  initial begin
    RST_N = 1'b0;
    SW_N  = 8'hFF;
    test_reset();
    test_debounce();
    test_single();
    test_round_robin();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
